// File: rtl/stream_upsizer.sv
// stream_upsizer: packs Ratio narrow valid/ready beats into one wide word with a lane strobe
module stream_upsizer #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Ratio     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [DataWidth-1:0]          data_i,
  input  logic                          last_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DataWidth*Ratio-1:0]    data_o,
  output logic [Ratio-1:0]              strb_o,
  output logic                          last_o
);
  localparam int unsigned LaneW = $clog2(Ratio);

  if (Ratio < 2) begin : g_ratio_check
    $error("stream_upsizer: Ratio must be >= 2");
  end

  logic [LaneW-1:0]                lane_q;
  logic [Ratio-2:0][DataWidth-1:0] fill_q;
  logic [Ratio-2:0]                fstrb_q;
  logic                            completes;
  logic                            fire;
  logic [DataWidth*Ratio-1:0]      word;
  logic [Ratio-1:0]                word_strb;

  assign completes = (lane_q == LaneW'(Ratio - 1)) || last_i;
  assign ready_o   = !flush_i && (!completes || !valid_o || ready_i);
  assign fire      = valid_i && ready_o;

  // Word a completing beat would emit; lanes at and above lane_q are still zero in the buffer
  always_comb begin
    word      = {{DataWidth{1'b0}}, fill_q};
    word_strb = {1'b0, fstrb_q};
    for (int k = 0; k < Ratio; k++) begin
      if (lane_q == LaneW'(k)) begin
        word[k*DataWidth +: DataWidth] = data_i;
        word_strb[k]                   = 1'b1;
      end
    end
  end

  // Fill buffer and lane pointer; cleared on flush and whenever a word completes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q  <= '0;
      fill_q  <= '0;
      fstrb_q <= '0;
    end else if (flush_i || (fire && completes)) begin
      lane_q  <= '0;
      fill_q  <= '0;
      fstrb_q <= '0;
    end else if (fire) begin
      fill_q[lane_q]  <= data_i;
      fstrb_q[lane_q] <= 1'b1;
      lane_q          <= lane_q + LaneW'(1);
    end
  end

  // Output register: a completing load wins over a drain so back-to-back words keep valid_o high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      strb_o  <= '0;
      last_o  <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      strb_o  <= '0;
      last_o  <= 1'b0;
    end else if (fire && completes) begin
      valid_o <= 1'b1;
      data_o  <= word;
      strb_o  <= word_strb;
      last_o  <= last_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_o && !ready_i && !flush_i |=> valid_o && $stable(data_o) && $stable(strb_o) && $stable(last_o));
  a_strb : assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_o |-> strb_o[0] && ((strb_o & (strb_o + 1'b1)) == '0));
`endif
endmodule

// File: tb/tb_stream_upsizer.sv
// tb_stream_upsizer: directed and random checks of stream_upsizer against a queue-based model
module tb_stream_upsizer;
  localparam int R = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0, valid_i = 1'b0, last_i = 1'b0, ready_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic ready_o, valid_o, last_o;
  logic [DW*R-1:0] data_o;
  logic [R-1:0] strb_o;

  int total = 0;
  int bad = 0;

  logic [7:0]  mq[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_strb = '0;
  logic        m_last = 1'b0;
  logic [36:0] log_q[$];

  stream_upsizer #(.DataWidth(DW), .Ratio(R)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .last_i(last_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .strb_o(strb_o), .last_o(last_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: beats collect in a queue; a completing beat turns the queue into a word
  always @(negedge clk) begin
    logic complete, m_ready, drained;
    if (!rst_n) begin
      mq.delete();
      m_valid = 1'b0;
      m_data = '0;
      m_strb = '0;
      m_last = 1'b0;
      chk("rst_valid", valid_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_strb", strb_o, 0);
      chk("rst_last", last_o, 0);
    end else begin
      complete = (mq.size() == R - 1) || last_i;
      m_ready = !flush_i && (!complete || !m_valid || ready_i);
      chk("ready", ready_o, m_ready);
      chk("valid", valid_o, m_valid);
      if (m_valid) begin
        chk("data", data_o, m_data);
        chk("strb", strb_o, m_strb);
        chk("last", last_o, m_last);
      end
      if (valid_o && ready_i) log_q.push_back({last_o, strb_o, data_o});
      if (flush_i) begin
        mq.delete();
        m_valid = 1'b0;
      end else begin
        drained = m_valid && ready_i;
        if (valid_i && m_ready) begin
          mq.push_back(data_i);
          if (complete) begin
            m_data = '0;
            foreach (mq[i]) m_data[i*8 +: 8] = mq[i];
            m_strb = 4'((1 << mq.size()) - 1);
            m_last = last_i;
            m_valid = 1'b1;
            mq.delete();
          end else if (drained) m_valid = 1'b0;
        end else if (drained) m_valid = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    bit ok;
    ok = 0;
    valid_i = 1'b1;
    data_i = d;
    last_i = l;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = ready_o;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: got no accept for %0h expected accept", d);
    end
    valid_i = 1'b0;
    last_i = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    rst_n = 1'b1;
    ready_i = 1'b1;
    cyc();
    // full word, back to back
    beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
    chk("t1_valid", valid_o, 1);
    chk("t1_data", data_o, 32'h44332211);
    chk("t1_strb", strb_o, 4'b1111);
    chk("t1_last", last_o, 0);
    // early termination
    beat(8'hA1, 0); beat(8'hA2, 1);
    chk("t2_data", data_o, 32'h0000A2A1);
    chk("t2_strb", strb_o, 4'b0011);
    chk("t2_last", last_o, 1);
    beat(8'hB0, 1);
    chk("t2_lane0_data", data_o, 32'h000000B0);
    chk("t2_lane0_strb", strb_o, 4'b0001);
    // continuous stream
    cyc(); cyc();
    log_q.delete();
    for (int i = 1; i <= 12; i++) beat(8'(i), 0);
    repeat (3) cyc();
    chk("t3_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t3_w0", log_q[0], {1'b0, 4'hF, 32'h04030201});
      chk("t3_w1", log_q[1], {1'b0, 4'hF, 32'h08070605});
      chk("t3_w2", log_q[2], {1'b0, 4'hF, 32'h0C0B0A09});
    end
    // backpressure
    ready_i = 1'b0;
    log_q.delete();
    for (int i = 1; i <= 7; i++) beat(8'(i), 0);
    valid_i = 1'b1;
    data_i = 8'h08;
    @(negedge clk);
    chk("t4_stall_ready", ready_o, 0);
    chk("t4_hold_data", data_o, 32'h04030201);
    cyc();
    @(negedge clk);
    chk("t4_stall_ready2", ready_o, 0);
    chk("t4_hold_data2", data_o, 32'h04030201);
    cyc();
    ready_i = 1'b1;
    @(negedge clk);
    chk("t4_release_ready", ready_o, 1);
    cyc();
    valid_i = 1'b0;
    chk("t4_next_valid", valid_o, 1);
    chk("t4_next_data", data_o, 32'h08070605);
    chk("t4_drained", log_q.size() > 0 ? log_q[0] : 37'h0, {1'b0, 4'hF, 32'h04030201});
    cyc();
    // flush
    beat(8'h50, 0); beat(8'h51, 0);
    flush_i = 1'b1;
    valid_i = 1'b1;
    data_i = 8'h99;
    @(negedge clk);
    chk("t5_flush_ready", ready_o, 0);
    cyc();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("t5_flush_valid", valid_o, 0);
    beat(8'h55, 0); beat(8'h56, 0); beat(8'h57, 0); beat(8'h58, 0);
    chk("t5_data", data_o, 32'h58575655);
    chk("t5_strb", strb_o, 4'b1111);
    cyc();
    // asynchronous reset mid-word with a pending word
    ready_i = 1'b0;
    for (int i = 0; i < 7; i++) beat(8'(8'h70 + i), 0);
    chk("t6_pending", valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", valid_o, 0);
    chk("t6_async_data", data_o, 0);
    cyc();
    rst_n = 1'b1;
    ready_i = 1'b1;
    beat(8'h61, 0); beat(8'h62, 0); beat(8'h63, 0); beat(8'h64, 0);
    chk("t6_data", data_o, 32'h64636261);
    chk("t6_strb", strb_o, 4'b1111);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      valid_i = $urandom_range(0, 3) != 0;
      data_i = 8'($urandom);
      last_i = $urandom_range(0, 4) == 0;
      ready_i = $urandom_range(0, 3) != 0;
      flush_i = $urandom_range(0, 40) == 0;
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end else cyc();
    end
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_upsizer.md
Name: stream_upsizer

Overview:
- Valid/ready width converter that packs `Ratio` consecutive narrow beats into one wide beat.
- Sits directly downstream of `stream_fifo` / `spill_register` on narrow byte streams. Feeds wide consumers such as `sram` write ports or wide `stream_fifo`s.
- Supports early termination through `last_i`, which emits a partial word with a lane strobe.
- Sustains one narrow beat per cycle.

Parameters:
- `DataWidth`, 8, width of one narrow beat (>=1).
- `Ratio`, 4, narrow beats per wide word (>=2; elaboration assertion).
- `LaneW` (localparam), `$clog2(Ratio)`, lane index width.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  synchronous clear of all buffered state.
- `valid_i`  in  1  narrow beat valid.
- `ready_o`  out  1  narrow beat accepted.
- `data_i`  in  `DataWidth`  narrow beat data.
- `last_i`  in  1  close the current word after this beat.
- `valid_o`  out  1  wide word valid.
- `ready_i`  in  1  wide word accepted.
- `data_o`  out  `DataWidth*Ratio`  wide word. Lane k is `data_o[k*DataWidth +: DataWidth]`; lane 0 holds the first beat.
- `strb_o`  out  `Ratio`  lane filled mask.
- `last_o`  out  1  word was closed by `last_i`.

Behaviour:
- **Reset (async, `rst_ni`=0):** `lane_q`=0; fill buffer, `strb` buffer and output register all zero; `valid_o`=0, `data_o`=0, `strb_o`=0, `last_o`=0.
- **State:**
  - Fill buffer: `Ratio-1` lanes plus a strobe.
  - `lane_q`: next lane to write, range 0..`Ratio-1`.
  - Output register: `data`, `strb`, `last`, `valid`.
- **Beat transfer:** occurs when `valid_i && ready_o`.
- **Completing beat:** the beat completes the word when `lane_q==Ratio-1 || last_i`.
- **`ready_o`:**
  - Equals `!flush_i && (!completes || !valid_o || ready_i)`.
  - It may depend on `last_i` but never on `valid_i`.
- **Non-completing transfer:** writes `data_i` into buffer lane `lane_q`, sets `strb[lane_q]`, and increments `lane_q`.
- **Completing transfer:**
  - The output register loads: buffer lanes `0..lane_q-1`, `data_i` at lane `lane_q`, and zero in unfilled lanes.
  - `strb_o` loads the lanes `0..lane_q` set; `last_o` loads `last_i`; `valid_o` is set.
  - The buffer, its strobe and `lane_q` clear to 0 in the same edge (wrap-around).
- **Latency:** the completing beat is visible on `valid_o` one cycle after its transfer. Non-completing beats produce no output.
- **Output handshake:**
  - `valid_o && ready_i` with no simultaneous completing transfer: `valid_o` goes to 0 next cycle.
  - Simultaneous drain and completing load: the register holds the new word and `valid_o` stays 1. Throughput is 1 beat/cycle.
- **Stability:** while `valid_o && !ready_i`, `data_o`, `strb_o` and `last_o` are stable. `valid_o` is never withdrawn except by flush or reset.
- **`last_i` on lane 0:** produces a word with `strb_o`=1 (single lane).
- **`flush_i`:**
  - Next edge: `lane_q`=0, buffers cleared, `valid_o`=0.
  - `ready_o`=0 in the flush cycle, so no beat is lost silently.
  - Flush has priority over every transfer in that cycle.
- **Reset mid-word:** partially filled lanes are discarded. After reset, the first beat lands in lane 0.
- **Unused lanes:** always drive 0 so downstream parity and hashing are deterministic.

Decomposition:
- No new package. Lane index and strobe widths are derived locally from the parameters.
- No sub-module. The output register is inline (not `spill_register`) so the 1-cycle latency and the simultaneous drain/load behaviour stay exact.
- Optional SVA block under `` `ifndef SYNTHESIS ``:
  - `valid_o` stable until handshake.
  - `strb_o` is contiguous from bit 0 and non-zero whenever `valid_o`.

Test Plan:
1. Reset, then `ready_i`=1 and beats 0x11,0x22,0x33,0x44 back-to-back, `last_i`=0. Required: one cycle after the 4th beat, `valid_o`=1, `data_o`=0x44332211, `strb_o`=4'b1111, `last_o`=0; `ready_o` stays 1 throughout.
2. Beats 0xA1,0xA2 with `last_i`=1 on 0xA2. Required: `data_o`=0x0000A2A1, `strb_o`=4'b0011, `last_o`=1; the next beat 0xB0 lands in lane 0.
3. Continuous 12 beats 0x01..0x0C with `ready_i`=1. Required: words 0x04030201, 0x08070605, 0x0C0B0A09 on consecutive 4-cycle boundaries; `ready_o` is never 0.
4. `ready_i`=0 with 8 beats offered. Required: the first word is held stable; the 4th beat of the second word sees `ready_o`=0. Raising `ready_i` drains 0x..04030201 and accepts the stalled beat in the same cycle.
5. 2 beats then `flush_i` pulse. Required: `ready_o`=0 in the flush cycle and `valid_o`=0 after it; the next 4 beats 0x55..0x58 yield 0x58575655 with `strb_o`=4'b1111.
6. Assert `rst_ni`=0 asynchronously mid-cycle after 3 beats with an output word pending. Required: `valid_o` drops immediately without a clock edge; after release, beats 0x61..0x64 give 0x64636261.
